fp_normalize_pipe: RTL and testbench

- Pipelined, parametrised normaliser for the FP adder/subtractor datapath. Sits after the significand add/sub.
- Accepts a raw significand sum, either unsigned with carry-out or two's-complement signed, plus the provisional exponent.
- Produces a normalised significand (MSB = 1), the adjusted exponent, a sign, and exception flags.
- Uses a 2-stage valid/ready pipeline with full back-pressure.

---
 rtl/fp_norm_pkg.sv | 27 ++
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_normalize_pipe.sv | 171 +++++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared definitions for the floating-point normaliser datapath: default
// widths, shift-count width derivation, the infinity exponent code and the
// exception flag bundle.
package fp_norm_pkg;

  localparam int SIG_W_DEF = 25;
  localparam int EXP_W_DEF = 8;

  // Shift counts must be able to represent the full significand width
  // (an all-zero significand reports a count equal to its width).
  function automatic int sh_width(input int sig_w);
    return $clog2(sig_w + 1);
  endfunction

  localparam int SH_W_DEF = sh_width(SIG_W_DEF);

  // All-ones exponent encodes overflow / infinity.
  localparam logic [EXP_W_DEF-1:0] EXP_INF = '1;

  typedef struct packed {
    logic zero;
    logic unf;
    logic ovf;
    logic sticky;
  } fp_flags_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter. Reports W when the input is all zero.
// Shared between the adder and multiplier normalisers.
module fp_lzc #(
  parameter int W  = 25,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [OW-1:0] o_count
);

  // Scan from LSB upward so the highest set bit is the one that sticks.
  always_comb begin
    o_count = OW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_count = OW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage valid/ready normaliser placed after the significand add/sub.
// Stage 1 forms the magnitude, sign and leading-zero count; stage 2 performs
// the left/right shift, adjusts the exponent and raises exception flags.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int SH_W  = sh_width(SIG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_signed,
  input  logic             cout_in,
  input  logic [SIG_W-1:0] sig_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] sig_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             sign_out,
  output logic [SH_W-1:0]  shift_out,
  output logic             sticky_out,
  output logic             zero_out,
  output logic             unf_out,
  output logic             ovf_out
);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [SIG_W:0]   r_s1_mag;
  logic             r_s1_sign;
  logic [SH_W-1:0]  r_s1_lzc;
  logic [EXP_W-1:0] r_s1_exp;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [SIG_W-1:0] r_sig;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic [SH_W-1:0]  r_shift;
  fp_flags_t        r_flags;

  // Handshake wires
  logic w_s2_advance;
  logic w_in_ready;

  // Stage 1 combinational
  logic [SIG_W-1:0] w_abs;
  logic [SIG_W:0]   w_mag;
  logic             w_sign;
  logic [SH_W-1:0]  w_lzc;

  // Stage 2 combinational
  logic [EXP_W:0]   w_exp_inc;
  logic [EXP_W:0]   w_exp_diff;
  logic [SIG_W-1:0] w_s2_sig;
  logic [EXP_W-1:0] w_s2_exp;
  logic             w_s2_sign;
  logic [SH_W-1:0]  w_s2_shift;
  fp_flags_t        w_s2_flags;

  assign w_s2_advance = !r_out_valid || out_ready;
  assign w_in_ready   = !r_s1_valid || w_s2_advance;
  assign in_ready     = w_in_ready;

  // Two's-complement negate; -2^(SIG_W-1) maps to 2^(SIG_W-1), which is
  // representable once the result is treated as unsigned.
  assign w_abs  = sig_in[SIG_W-1] ? (~sig_in + SIG_W'(1)) : sig_in;
  assign w_mag  = mode_signed ? {1'b0, w_abs} : {cout_in, sig_in};
  assign w_sign = mode_signed & sig_in[SIG_W-1];

  fp_lzc #(
    .W  (SIG_W),
    .OW (SH_W)
  ) u_lzc (
    .i_data  (w_mag[SIG_W-1:0]),
    .o_count (w_lzc)
  );

  // Exponent arithmetic carried one bit wider: the top bit of the difference
  // acts as the sign, the top bit of the increment catches wrap-around.
  assign w_exp_inc  = {1'b0, r_s1_exp} + (EXP_W+1)'(1);
  assign w_exp_diff = {1'b0, r_s1_exp} - (EXP_W+1)'(r_s1_lzc);

  // Stage 2 shift, exponent adjust and flag generation
  always_comb begin
    w_s2_sig   = '0;
    w_s2_exp   = '0;
    w_s2_sign  = r_s1_sign;
    w_s2_shift = '0;
    w_s2_flags = '0;
    if (r_s1_mag == '0) begin
      w_s2_sign       = 1'b0;
      w_s2_flags.zero = 1'b1;
    end else if (r_s1_mag[SIG_W]) begin
      w_s2_flags.sticky = r_s1_mag[0];
      if (w_exp_inc >= {1'b0, EXP_ONES}) begin
        w_s2_flags.ovf = 1'b1;
        w_s2_exp       = EXP_ONES;
      end else begin
        w_s2_sig = r_s1_mag[SIG_W:1];
        w_s2_exp = w_exp_inc[EXP_W-1:0];
      end
    end else begin
      w_s2_shift = r_s1_lzc;
      // Result exponent below 1 (negative or zero): flush to zero.
      if (w_exp_diff[EXP_W] || (w_exp_diff == '0)) begin
        w_s2_flags.unf = 1'b1;
      end else begin
        w_s2_sig = r_s1_mag[SIG_W-1:0] << r_s1_lzc;
        w_s2_exp = w_exp_diff[EXP_W-1:0];
      end
    end
  end

  // Stage 1 register: loads whenever it is empty or its beat moves on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_lzc   <= '0;
      r_s1_exp   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mag  <= w_mag;
        r_s1_sign <= w_sign;
        r_s1_lzc  <= w_lzc;
        r_s1_exp  <= exp_in;
      end
    end
  end

  // Stage 2 register: outputs hold while a beat is stalled downstream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sig       <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_shift     <= '0;
      r_flags     <= '0;
    end else if (w_s2_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sig   <= w_s2_sig;
        r_exp   <= w_s2_exp;
        r_sign  <= w_s2_sign;
        r_shift <= w_s2_shift;
        r_flags <= w_s2_flags;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign sig_out    = r_sig;
  assign exp_out    = r_exp;
  assign sign_out   = r_sign;
  assign shift_out  = r_shift;
  assign sticky_out = r_flags.sticky;
  assign zero_out   = r_flags.zero;
  assign unf_out    = r_flags.unf;
  assign ovf_out    = r_flags.ovf;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe (SIG_W=25, EXP_W=8).
module tb_fp_normalize_pipe;

  localparam int SIG_W = 25;
  localparam int EXP_W = 8;
  localparam int SH_W  = 5;
  localparam int NVEC  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             mode_signed;
  logic             cout_in;
  logic [SIG_W-1:0] sig_in;
  logic [EXP_W-1:0] exp_in;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W-1:0] sig_out;
  logic [EXP_W-1:0] exp_out;
  logic             sign_out;
  logic [SH_W-1:0]  shift_out;
  logic             sticky_out;
  logic             zero_out;
  logic             unf_out;
  logic             ovf_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_normalize_pipe #(
    .SIG_W (SIG_W),
    .EXP_W (EXP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode_signed (mode_signed),
    .cout_in     (cout_in),
    .sig_in      (sig_in),
    .exp_in      (exp_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sig_out     (sig_out),
    .exp_out     (exp_out),
    .sign_out    (sign_out),
    .shift_out   (shift_out),
    .sticky_out  (sticky_out),
    .zero_out    (zero_out),
    .unf_out     (unf_out),
    .ovf_out     (ovf_out)
  );

  typedef struct {
    logic             mode;
    logic             cout;
    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] e_sig;
    logic [EXP_W-1:0] e_exp;
    logic             e_sign;
    logic [SH_W-1:0]  e_shift;
    logic             e_sticky;
    logic             e_zero;
    logic             e_unf;
    logic             e_ovf;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return 64'({sig_out, exp_out, sign_out, shift_out, sticky_out, zero_out, unf_out, ovf_out});
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t v);
    return 64'({v.e_sig, v.e_exp, v.e_sign, v.e_shift, v.e_sticky, v.e_zero, v.e_unf, v.e_ovf});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_block;
    int sent;
    int got;
    logic [63:0] prev;
    logic prev_stall;
    logic ghost;

    //            mode cout sig           exp     e_sig         e_exp  sgn sh  st z  u  o
    vecs[0]  = '{1'b0, 1'b0, 25'h1000000, 8'd100, 25'h1000000, 8'd100, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 25'h0000001, 8'd100, 25'h1000000, 8'd76,  1'b0, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 25'h0000001, 8'd10,  25'h0000000, 8'd0,   1'b0, 5'd24, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 25'h1000001, 8'd200, 25'h1800000, 8'd201, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 25'h1000001, 8'd254, 25'h0000000, 8'hFF,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 25'h1FFFFFF, 8'd30,  25'h1000000, 8'd6,   1'b1, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 25'h1000000, 8'd30,  25'h1000000, 8'd30,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 25'h0000000, 8'd77,  25'h0000000, 8'd0,   1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 25'h0000000, 8'd77,  25'h0000000, 8'd0,   1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 25'h0000000, 8'd77,  25'h1000000, 8'd78,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 25'h1FFFFFF, 8'd24,  25'h0000000, 8'd0,   1'b1, 5'd24, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 25'h1FFFFFF, 8'd25,  25'h1000000, 8'd1,   1'b1, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 25'h1000000, 8'd253, 25'h1800000, 8'd254, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 25'h0000003, 8'd50,  25'h1800000, 8'd27,  1'b0, 5'd23, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 25'h0000003, 8'd50,  25'h1800000, 8'd27,  1'b0, 5'd23, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 25'h0012345, 8'd200, 25'h1234500, 8'd192, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    mode_signed = 1'b0;
    cout_in     = 1'b0;
    sig_in      = '0;
    exp_in      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", pack_out(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);

    // Directed vector table, one beat at a time through an idle pipe
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      mode_signed = vecs[i].mode;
      cout_in     = vecs[i].cout;
      sig_in      = vecs[i].sig;
      exp_in      = vecs[i].exp;
      in_valid    = 1'b1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_latency_early", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_outputs", i), pack_out(), pack_exp(vecs[i]));
      $display("vec%0d: sig=%h exp=%0d sign=%0b shift=%0d st=%0b z=%0b u=%0b o=%0b",
               i, sig_out, exp_out, sign_out, shift_out, sticky_out, zero_out, unf_out, ovf_out);
    end

    // Back-pressure: 5 beats, out_ready low for the first 4 cycles
    @(negedge clk);
    first_block = -1;
    sent        = 0;
    got         = 0;
    prev        = '0;
    prev_stall  = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          int waits;
          @(negedge clk);
          #1;
          mode_signed = 1'b0;
          cout_in     = 1'b0;
          sig_in      = 25'h1000000 | 25'(k * 3 + 1);
          exp_in      = 8'(40 + k);
          in_valid    = 1'b1;
          waits       = 0;
          while (!in_ready && waits < 50) begin
            if (first_block < 0) first_block = sent;
            @(negedge clk);
            #1;
            waits++;
          end
          if (waits >= 50) begin
            chk("bp_in_timeout", 64'd0, 64'd1);
            break;
          end
          sent++;
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60 && got < 5; c++) begin
          @(negedge clk);
          out_ready = (c >= 4);
          if (out_valid && !out_ready) begin
            if (prev_stall) chk("bp_stable", pack_out(), prev);
            prev       = pack_out();
            prev_stall = 1'b1;
          end else begin
            prev_stall = 1'b0;
          end
          if (out_valid && out_ready) begin
            chk($sformatf("bp_beat%0d", got), 64'({sig_out, exp_out}),
                64'({25'h1000000 | 25'(got * 3 + 1), 8'(40 + got)}));
            $display("bp beat%0d: sig=%h exp=%0d", got, sig_out, exp_out);
            got++;
          end
        end
      end
    join
    chk("bp_count", 64'(got), 64'd5);
    chk("bp_block_after", 64'(first_block), 64'd2);

    // Reset with two beats in flight
    @(negedge clk);
    out_ready   = 1'b0;
    mode_signed = 1'b0;
    cout_in     = 1'b0;
    sig_in      = 25'h1555555;
    exp_in      = 8'd90;
    in_valid    = 1'b1;
    @(negedge clk);
    sig_in = 25'h1AAAAAA;
    exp_in = 8'd91;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_inflight_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", pack_out(), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    ghost     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    chk("rst_no_ghost_beats", 64'(ghost), 64'd0);
    $display("reset flush: out_valid stayed %0b", ghost);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
